// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Consumed by mem_arb_pick and mem_port_arbiter.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_FETCH = 2'd0;
    localparam req_idx_t REQ_LOAD  = 2'd1;
    localparam req_idx_t REQ_STORE = 2'd2;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    typedef enum logic {
        ARB_IDLE,
        ARB_RD_RESP
    } arb_state_e;

    // Next requester index in round-robin order, wrapping store -> fetch.
    function automatic req_idx_t rr_next(input req_idx_t idx);
        return (idx >= REQ_STORE) ? REQ_FETCH : idx + 2'd1;
    endfunction

    function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        req_idx_t idx;
        idx = REQ_FETCH;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (oh[r]) idx = req_idx_t'(r);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: round-robin from ptr+1 when MEM_ARB_RR_EN is
// defined, otherwise fixed priority load > store > fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef MEM_ARB_RR_EN
    input  req_idx_t           ptr,
`endif
    output logic [NUM_REQ-1:0] win
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        req_idx_t cand;
        win  = '0;
        cand = rr_next(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if ((win == '0) && req[cand]) begin
                win[cand] = 1'b1;
            end
            cand = rr_next(cand);
        end
    end
`else
    always_comb begin
        win = '0;
        if (req[REQ_LOAD]) begin
            win[REQ_LOAD] = 1'b1;
        end else if (req[REQ_STORE]) begin
            win[REQ_STORE] = 1'b1;
        end else if (req[REQ_FETCH]) begin
            win[REQ_FETCH] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between fetch, load and store; two-cycle reads,
// single-cycle writes. Arbitration policy selected by MEM_ARB_RR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0]                   we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]       addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]       wdata,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]     wstrb,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   rvalid,
    output logic [DATA_W-1:0]                    rdata,
    output logic                                 mem_rw_mode,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [DATA_W-1:0]                    mem_wdata,
    output logic [DATA_W/8-1:0]                  mem_wstrb,
    input  logic [DATA_W-1:0]                    mem_rdata,
    output logic                                 busy
);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] rvalid_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] win;
    logic               rd_grant;

`ifdef MEM_ARB_RR_EN
    req_idx_t ptr_q;
`endif

    mem_arb_pick u_pick (
        .req (req),
`ifdef MEM_ARB_RR_EN
        .ptr (ptr_q),
`endif
        .win (win)
    );

    assign gnt      = (state_q == ARB_IDLE) ? win : '0;
    assign rd_grant = |(gnt & ~we);

    // Bus parks in read mode with zeros whenever nothing is granted.
    always_comb begin
        mem_rw_mode = MEM_RD;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
                mem_rw_mode = we[r] ? MEM_WR : MEM_RD;
                mem_addr    = addr[r];
                mem_wdata   = wdata[r];
                mem_wstrb   = we[r] ? wstrb[r] : '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ARB_IDLE;
            rvalid_q <= '0;
            busy_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q    <= REQ_STORE;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (rd_grant) begin
                        state_q  <= ARB_RD_RESP;
                        rvalid_q <= gnt;
                        busy_q   <= 1'b1;
                    end
`ifdef MEM_ARB_RR_EN
                    if (|gnt) begin
                        ptr_q <= onehot_to_idx(gnt);
                    end
`endif
                end
                ARB_RD_RESP: begin
                    state_q  <= ARB_IDLE;
                    rvalid_q <= '0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q  <= ARB_IDLE;
                    rvalid_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rvalid = rvalid_q;
    assign busy   = busy_q;
    assign rdata  = (|rvalid_q) ? mem_rdata : '0;

    a_gnt_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(gnt));
    a_gnt_rvalid: assert property (@(posedge i_clk) disable iff (i_rst) (gnt & rvalid) == '0);
    a_rd_no_gnt:  assert property (@(posedge i_clk) disable iff (i_rst)
                                   (state_q == ARB_RD_RESP) |-> (gnt == '0));

endmodule
